// File: rtl/bongo_responder.sv
// rtl/bongo_responder.sv - bongo bus device endpoint: host frame decoder and pulse-width reply transmitter
// Answers identify frames with DEVICE_ID and poll frames with a status_word snapshot.
module bongo_responder #(
   parameter int unsigned CLKS_PER_US = 50,
   parameter logic [23:0] DEVICE_ID   = 24'h090000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_in,
   input  logic [63:0] status_word,
   output logic        data_oe,
   output logic        poll_seen,
   output logic        rx_error,
   output logic        busy
);

   localparam int unsigned CW = $clog2(16 * CLKS_PER_US);
   localparam logic [CW-1:0] T_SAMPLE  = CW'(2 * CLKS_PER_US - 1);
   localparam logic [CW-1:0] T_LOWMAX  = CW'(5 * CLKS_PER_US);
   localparam logic [CW-1:0] T_HIGHEND = CW'(5 * CLKS_PER_US - 2);
   localparam logic [CW-1:0] T_TURN    = CW'(2 * CLKS_PER_US - 2);
   localparam logic [CW-1:0] T_CELL    = CW'(4 * CLKS_PER_US - 1);
   localparam logic [CW-1:0] T_STOP    = CW'(2 * CLKS_PER_US - 1);
   localparam logic [CW-1:0] W_ONE     = CW'(CLKS_PER_US);
   localparam logic [CW-1:0] W_ZERO    = CW'(3 * CLKS_PER_US);

   typedef enum logic [2:0] {
      IDLE, RX_LOW, RX_HIGH, DECODE, TURNAROUND, TX_BIT, TX_STOP
   } state_t;

   state_t        state;
   logic [1:0]    sync_q;
   logic          line_d;
   logic [CW-1:0] cnt;
   logic [CW-1:0] hcnt;
   logic [24:0]   rx_sr;
   logic [6:0]    rx_bits;
   logic [6:0]    tx_left;
   logic [63:0]   tx_sr;

   logic          line;
   logic          fall;
   logic          rise;
   logic [CW-1:0] cnt_nxt;
   logic [CW-1:0] tx_low;

   assign line    = sync_q[1];
   assign fall    = line_d & ~line;
   assign rise    = ~line_d & line;
   assign cnt_nxt = cnt + 1'b1;
   assign tx_low  = tx_sr[63] ? W_ONE : W_ZERO;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sync_q    <= '0;
         line_d    <= 1'b0;
         cnt       <= '0;
         hcnt      <= '0;
         rx_sr     <= '0;
         rx_bits   <= '0;
         tx_left   <= '0;
         tx_sr     <= '0;
         data_oe   <= 1'b0;
         poll_seen <= 1'b0;
         rx_error  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], data_in};
         line_d    <= line;
         poll_seen <= 1'b0;
         rx_error  <= 1'b0;
         case (state)
            IDLE: begin
               data_oe <= 1'b0;
               busy    <= 1'b0;
               if (fall) begin
                  state   <= RX_LOW;
                  cnt     <= '0;
                  rx_sr   <= '0;
                  rx_bits <= '0;
                  busy    <= 1'b1;
               end
            end
            RX_LOW, RX_HIGH: begin
               cnt  <= cnt_nxt;
               hcnt <= hcnt + 1'b1;
               // cnt restarts on every host falling edge, so this is the mid-cell sample
               if (cnt == T_SAMPLE) begin
                  rx_sr <= {rx_sr[23:0], line};
                  if (rx_bits != 7'd25) rx_bits <= rx_bits + 1'b1;
               end
               if (state == RX_LOW) begin
                  if (rise) begin
                     state <= RX_HIGH;
                     hcnt  <= '0;
                  end else if (cnt == T_LOWMAX) begin
                     rx_error <= 1'b1;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end
               end else begin
                  if (fall) begin
                     state <= RX_LOW;
                     cnt   <= '0;
                  end else if (hcnt == T_HIGHEND) begin
                     state <= DECODE;
                  end
               end
            end
            DECODE: begin
               cnt <= '0;
               if (rx_bits == 7'd9 && rx_sr == 25'd1) begin
                  tx_sr   <= {DEVICE_ID, 40'h0};
                  tx_left <= 7'd24;
                  state   <= TURNAROUND;
               end else if (rx_bits == 7'd25 && rx_sr[24:17] == 8'h40 && rx_sr[0]) begin
                  tx_sr     <= status_word;
                  tx_left   <= 7'd64;
                  poll_seen <= 1'b1;
                  state     <= TURNAROUND;
               end else begin
                  rx_error <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            TURNAROUND: begin
               cnt <= cnt_nxt;
               if (cnt == T_TURN) begin
                  state   <= TX_BIT;
                  cnt     <= '0;
                  data_oe <= 1'b1;
               end
            end
            TX_BIT: begin
               // data_oe is registered, so each decision is for the following cycle
               if (cnt == T_CELL) begin
                  cnt     <= '0;
                  data_oe <= 1'b1;
                  if (tx_left == 7'd1) begin
                     state <= TX_STOP;
                  end else begin
                     tx_left <= tx_left - 1'b1;
                     tx_sr   <= {tx_sr[62:0], 1'b0};
                  end
               end else begin
                  cnt     <= cnt_nxt;
                  data_oe <= (cnt_nxt < tx_low);
               end
            end
            TX_STOP: begin
               cnt <= cnt_nxt;
               if (cnt == T_STOP) begin
                  data_oe <= 1'b0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  data_oe <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bongo_responder.sv
// tb/tb_bongo_responder.sv - self-checking bench for bongo_responder
// Host frames come from a table, hand sequences and random draws; replies are checked as low-pulse widths.
module tb_bongo_responder;

   // scaled protocol clock keeps the run short; all widths below follow from it
   localparam int US = 10;
   localparam logic [23:0] DEV_ID = 24'h090000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        host_low = 1'b0;
   logic        data_in;
   logic [63:0] status_word = '0;
   logic        data_oe;
   logic        poll_seen;
   logic        rx_error;
   logic        busy;

   // open-drain bus: either side pulling low wins, so the DUT sees its own echo
   assign data_in = ~(host_low | data_oe);

   bongo_responder #(.CLKS_PER_US(US), .DEVICE_ID(DEV_ID)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .status_word(status_word),
      .data_oe(data_oe), .poll_seen(poll_seen), .rx_error(rx_error), .busy(busy)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   bit   mon_clear = 1'b0;
   int   widths[$];
   int   cyc = 0, run = 0, n_poll = 0, n_err = 0, n_long = 0, n_both = 0;
   int   first_rise = -1, last_fall = -1, busy_fall = -1, poll_cyc = -1;
   logic oe_q = 1'b0, ps_q = 1'b0, er_q = 1'b0, busy_q = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (mon_clear) begin
            widths.delete();
            run = 0; n_poll = 0; n_err = 0; n_long = 0; n_both = 0;
            first_rise = -1; last_fall = -1; busy_fall = -1; poll_cyc = -1;
         end else begin
            if (data_oe === 1'b1) run++;
            else if (run > 0) begin
               widths.push_back(run);
               run = 0;
               last_fall = cyc;
            end
            if (data_oe === 1'b1 && oe_q !== 1'b1 && first_rise < 0) first_rise = cyc;
            if (poll_seen === 1'b1) begin n_poll++; poll_cyc = cyc; end
            if (rx_error === 1'b1) n_err++;
            if (poll_seen === 1'b1 && rx_error === 1'b1) n_both++;
            if (poll_seen === 1'b1 && ps_q === 1'b1) n_long++;
            if (rx_error === 1'b1 && er_q === 1'b1) n_long++;
            if (busy === 1'b0 && busy_q === 1'b1) busy_fall = cyc;
         end
         oe_q = data_oe; ps_q = poll_seen; er_q = rx_error; busy_q = busy;
         cyc++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      mon_clear = 1'b1;
      @(negedge clk);
      #1 mon_clear = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      host_low = 1'b1;
      repeat (b ? US : 3 * US) @(negedge clk);
      host_low = 1'b0;
      repeat (b ? 3 * US : US) @(negedge clk);
   endtask

   task automatic send_frame(input logic [63:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
      send_bit(1'b1);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 4000 && busy !== 1'b0; i++) @(negedge clk);
      check({name, " busy end"}, busy, 1'b0);
      repeat (3 * US) @(negedge clk);
   endtask

   // reference: frame = command bits + stop 1; count saturates at 25 keeping the latest 25 bits
   function automatic int classify(input logic [63:0] bits, input int n);
      logic q[$];
      logic [7:0] hdr;
      for (int i = n - 1; i >= 0; i--) q.push_back(bits[i]);
      q.push_back(1'b1);
      while (q.size() > 25) void'(q.pop_front());
      hdr = '0;
      if (q.size() >= 8) for (int i = 0; i < 8; i++) hdr = {hdr[6:0], q[i]};
      if (q.size() == 9 && hdr == 8'h00 && q[8] == 1'b1) return 1;
      if (q.size() == 25 && hdr == 8'h40 && q[24] == 1'b1) return 2;
      return 0;
   endfunction

   task automatic check_reply(input string name, input logic [63:0] word, input int nb);
      int exp_w[$];
      int bad_idx;
      for (int i = 0; i < nb; i++) exp_w.push_back(word[63 - i] ? US : 3 * US);
      exp_w.push_back(2 * US);
      check({name, " pulse count"}, 64'(widths.size()), 64'(exp_w.size()));
      bad_idx = (widths.size() == exp_w.size()) ? -1 : -2;
      if (bad_idx == -1)
         for (int i = 0; i < exp_w.size(); i++)
            if (widths[i] != exp_w[i] && bad_idx == -1) bad_idx = i;
      check({name, " first bad width index"}, 64'(bad_idx), 64'(-1));
   endtask

   task automatic run_frame(input string name, input logic [63:0] bits, input int n,
                            input logic [63:0] st, input int kind);
      int nb;
      clear_mon();
      status_word = st;
      send_frame(bits, n);
      wait_idle(name);
      nb = (kind == 2) ? 64 : 24;
      check({name, " poll_seen"}, 64'(n_poll), 64'(kind == 2));
      check({name, " rx_error"}, 64'(n_err), 64'(kind == 0));
      check({name, " pulse shape"}, 64'(n_long + n_both), 64'(0));
      if (kind == 0) begin
         check({name, " no reply"}, 64'(widths.size()), 64'(0));
      end else begin
         check_reply(name, (kind == 2) ? st : {DEV_ID, 40'h0}, nb);
         check({name, " span"}, 64'(last_fall - first_rise), 64'(nb * 4 * US + 2 * US));
         check({name, " busy after release"}, 64'(busy_fall >= last_fall), 64'(1));
         if (kind == 2)
            check({name, " turnaround"}, 64'(first_rise - poll_cyc), 64'(2 * US - 1));
      end
   endtask

   typedef struct {
      logic [63:0] bits;
      int          n;
      logic [63:0] st;
      int          kind;
   } vec_t;

   initial begin
      vec_t vt[7];
      logic [63:0] old_st;
      logic [63:0] rbits;
      int rn, rk;
      bit found;

      vt[0] = '{64'h400300, 24, 64'h8000_0000_0000_0001, 2};
      vt[1] = '{64'h00, 8, 64'h0, 1};
      vt[2] = '{64'h41A5A5, 24, 64'h0, 0};
      vt[3] = '{64'h000, 9, 64'h0, 0};
      vt[4] = '{64'h4003, 16, 64'h0, 0};
      vt[5] = '{64'h40FFFF, 24, 64'hDEAD_BEEF_0123_4567, 2};
      vt[6] = '{64'h01, 8, 64'h0, 0};

      repeat (4) @(negedge clk);
      check("reset data_oe", data_oe, 1'b0);
      check("reset poll_seen", poll_seen, 1'b0);
      check("reset rx_error", rx_error, 1'b0);
      check("reset busy", busy, 1'b0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("idle busy", busy, 1'b0);

      for (int i = 0; i < 7; i++)
         run_frame($sformatf("vec%0d", i), vt[i].bits, vt[i].n, vt[i].st, vt[i].kind);

      // host holds the line low too long mid-frame
      clear_mon();
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      host_low = 1'b1;
      repeat (6 * US) @(negedge clk);
      host_low = 1'b0;
      repeat (10 * US) @(negedge clk);
      check("lowhold rx_error", 64'(n_err), 64'(1));
      check("lowhold no reply", 64'(widths.size() + n_poll), 64'(0));
      check("lowhold busy", busy, 1'b0);
      run_frame("after lowhold", 64'h400300, 24, 64'h0123_4567_89AB_CDEF, 2);

      // status_word changes right after the poll is accepted
      clear_mon();
      old_st = 64'hA5A5_0F0F_3C3C_9999;
      status_word = old_st;
      send_frame(64'h400300, 24);
      found = 1'b0;
      for (int i = 0; i < 20 * US && !found; i++) begin
         @(negedge clk);
         if (poll_seen === 1'b1) found = 1'b1;
      end
      check("late status poll_seen", found, 1'b1);
      @(negedge clk);
      status_word = ~old_st;
      wait_idle("late status");
      check_reply("late status", old_st, 64);

      // reset asserted while bit 30 of a reply is driving the bus
      clear_mon();
      status_word = 64'hFFFF_0000_FFFF_0000;
      send_frame(64'h400300, 24);
      found = 1'b0;
      for (int i = 0; i < 4000 && !found; i++) begin
         @(negedge clk);
         if (widths.size() == 29 && data_oe === 1'b1) found = 1'b1;
      end
      check("reset reached bit30", found, 1'b1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("reset async data_oe", data_oe, 1'b0);
      check("reset async busy", busy, 1'b0);
      check("reset async pulses", {poll_seen, rx_error}, 2'b00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      clear_mon();
      repeat (10 * US) @(negedge clk);
      check("post reset quiet", 64'(widths.size() + n_poll + n_err + 32'(busy)), 64'(0));
      run_frame("after reset", 64'h400300, 24, 64'h1357_9BDF_2468_ACE0, 2);

      for (int i = 0; i < 6; i++) begin
         case ($urandom_range(0, 2))
            0: begin rn = 8; rbits = '0; end
            1: begin rn = 24; rbits = {40'h0, 8'h40, 16'($urandom)}; end
            default: begin rn = $urandom_range(4, 26); rbits = {$urandom, $urandom}; end
         endcase
         rk = classify(rbits, rn);
         run_frame($sformatf("rand%0d", i), rbits, rn, {$urandom, $urandom}, rk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
